// File: rtl/alu_share_sched.sv
// alu_share_sched: round-robin scheduler sharing one 4-bit ALU datapath between two requesters.
module alu_share_sched (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    input  logic       op0,
    input  logic       op1,
    output logic       ack0,
    output logic       ack1,
    output logic [3:0] res0,
    output logic [3:0] res1,
    output logic [3:0] dp_data_in,
    output logic       dp_ld_1,
    output logic       dp_ld_2,
    output logic       dp_sel_1,
    output logic       dp_op,
    output logic       dp_en,
    input  logic [3:0] dp_data_out,
    output logic       busy,
    output logic       owner,
    output logic [2:0] state
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD1 = 3'd1,
        LOAD2 = 3'd2,
        EXEC  = 3'd3,
        WAIT  = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t     r_state;
    logic       r_owner, r_last;
    logic [3:0] r_a, r_b;
    logic       r_op;
    logic [3:0] r_data, r_res0, r_res1;
    logic       r_ld1, r_ld2, r_sel, r_en, r_dp_op, r_ack0, r_ack1;
    logic       w_grant;

    // on a tie the requester that was not served last wins
    assign w_grant = (req0 && req1) ? ~r_last : req1;

    // strobes are registered one edge ahead so they are clean Moore outputs of the state they belong to
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_a     <= 4'd0;
            r_b     <= 4'd0;
            r_op    <= 1'b0;
            r_data  <= 4'd0;
            r_res0  <= 4'd0;
            r_res1  <= 4'd0;
            r_ld1   <= 1'b0;
            r_ld2   <= 1'b0;
            r_sel   <= 1'b0;
            r_en    <= 1'b0;
            r_dp_op <= 1'b0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
        end else begin
            r_data  <= 4'd0;
            r_ld1   <= 1'b0;
            r_ld2   <= 1'b0;
            r_sel   <= 1'b0;
            r_en    <= 1'b0;
            r_dp_op <= 1'b0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            case (r_state)
                IDLE: if (req0 || req1) begin
                    r_state <= LOAD1;
                    r_owner <= w_grant;
                    r_last  <= w_grant;
                    r_a     <= w_grant ? a1 : a0;
                    r_b     <= w_grant ? b1 : b0;
                    r_op    <= w_grant ? op1 : op0;
                    r_data  <= w_grant ? a1 : a0;
                    r_ld1   <= 1'b1;
                end
                LOAD1: begin
                    r_state <= LOAD2;
                    r_data  <= r_b;
                    r_ld2   <= 1'b1;
                end
                LOAD2: begin
                    r_state <= EXEC;
                    r_sel   <= 1'b1;
                    r_en    <= 1'b1;
                    r_dp_op <= r_op;
                end
                EXEC: r_state <= WAIT;
                WAIT: begin
                    r_state <= DONE;
                    if (r_owner) begin
                        r_res1 <= dp_data_out;
                        r_ack1 <= 1'b1;
                    end else begin
                        r_res0 <= dp_data_out;
                        r_ack0 <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ack0       = r_ack0;
    assign ack1       = r_ack1;
    assign res0       = r_res0;
    assign res1       = r_res1;
    assign dp_data_in = r_data;
    assign dp_ld_1    = r_ld1;
    assign dp_ld_2    = r_ld2;
    assign dp_sel_1   = r_sel;
    assign dp_op      = r_dp_op;
    assign dp_en      = r_en;
    assign busy       = (r_state != IDLE);
    assign owner      = r_owner;
    assign state      = r_state;
endmodule

// File: doc/alu_share_sched.md
# alu_share_sched

Two-port scheduler that shares the single 4-bit ALU datapath between two independent requesters. It arbitrates round-robin and drives the datapath control strobes (`ld_1`, `ld_2`, `sel_1`, `op`, `en`) through a fixed load/load/execute/capture sequence. It returns the 4-bit result to the granted requester with a one-cycle acknowledge. It sits between the requesters and the datapath and replaces the standalone controller when the datapath is shared.

## Interface
Parameters: none; all widths are fixed at 4-bit data.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req0` / `req1`  in  1  level request from requester 0 / 1
- `a0`, `b0` / `a1`, `b1`  in  4 each  operands A and B of requester 0 / 1
- `op0` / `op1`  in  1  operation of requester 0 / 1; 0 = add, 1 = subtract
- `ack0` / `ack1`  out  1  one-cycle completion pulse to requester 0 / 1
- `res0` / `res1`  out  4  result register of requester 0 / 1
- `dp_data_in`  out  4  operand bus to the datapath
- `dp_ld_1`, `dp_ld_2`  out  1 each  load REG1 / REG2 from `dp_data_in`
- `dp_sel_1`, `dp_op`, `dp_en`  out  1 each  execute controls
- `dp_data_out`  in  4  registered datapath result
- `busy`  out  1  high whenever state ≠ IDLE
- `owner`  out  1  index of the current or last granted requester
- `state`  out  3  current FSM state, for debug

## Operation
- FSM encoding: IDLE=0, LOAD1=1, LOAD2=2, EXEC=3, WAIT=4, DONE=5. Codes 6 and 7 return to IDLE on the next edge with all outputs inactive.
- Transition sequence: IDLE → LOAD1 → LOAD2 → EXEC → WAIT → DONE → IDLE. Only IDLE waits; every other state lasts exactly one cycle.
- IDLE: if any `req` is high at the edge, the scheduler:
  - grants one requester;
  - latches that requester's A, B and op into internal shadow registers;
  - sets `owner`;
  - moves to LOAD1.
- Arbitration:
  - Single request: that requester is granted.
  - Both requesting: the requester ≠ `last_owner` is granted.
  - `last_owner` updates at grant.
- LOAD1: `dp_data_in` = shadow A, `dp_ld_1` = 1.
- LOAD2: `dp_data_in` = shadow B, `dp_ld_2` = 1.
- EXEC: `dp_sel_1` = 1, `dp_en` = 1, `dp_op` = shadow op.
- WAIT: all strobes 0. `dp_data_out` is sampled at the end of WAIT into `res[owner]`.
- DONE: `ack[owner]` = 1 for exactly this cycle, then IDLE.
- Strobes are Moore outputs of state. Outside their states `dp_data_in` = 0 and all strobes = 0. Never more than one of `dp_ld_1`, `dp_ld_2`, `dp_en` is high in a cycle.
- `res0` / `res1` hold their value until that requester's next job completes. A job never writes the other requester's result register.
- Requester contract:
  - Hold `req` high until served.
  - Operands may change freely after the grant edge.
  - Deassert `req` in the cycle `ack` is high. If `req` is still high when the FSM returns to IDLE, it counts as a new request.
- `req` dropped before grant: no job, no ack. `req` dropped after grant: the job completes and ack still pulses.
- Arithmetic is done by the datapath, mod 16 (4-bit wrap). The scheduler never alters result bits.

## Timing
- Reset (asynchronous, `rst_n` low), values take effect immediately:
  - state = IDLE; `busy` = 0; `owner` = 0; `last_owner` = 1, so requester 0 wins the first tie.
  - `ack0` = `ack1` = 0; `res0` = `res1` = 0.
  - All `dp_*` outputs = 0; shadow registers = 0.
- Reset mid-job aborts the job with no ack. A requester still holding `req` after reset release is served normally.
- Latency: `req` high at grant edge E → LOAD1 in cycle E+1, `dp_en` in cycle E+3, `ack` and valid `res` in cycle E+5.
- Job occupancy is 6 cycles including IDLE. Back-to-back jobs run one every 6 cycles.
- Under continuous requests from both, grants alternate strictly: 0, 1, 0, 1, …
- Datapath assumption: REG1/REG2 load on the edge ending LOAD1/LOAD2. The result registers on the edge ending EXEC and is valid on `dp_data_out` throughout WAIT.

## Test plan
Bench uses a behavioural datapath: on `dp_en`, result ← op ? REG1−REG2 : REG1+REG2 (mod 16), registered.
- Single request: `req0`, A=3, B=4, op=0 → `ack0` 5 cycles after grant, `res0`=7, `res1` stays 0, `owner`=0.
- Subtract with wrap: `req1`, A=2, B=5, op=1 → `res1`=13 (0xD); strobes seen in order `ld_1` (data 2), `ld_2` (data 5), `en`.
- Tie after reset: `req0` and `req1` rise in the same cycle → requester 0 served first, then requester 1 granted the cycle after `ack0`, with no idle gap beyond IDLE.
- Continuous contention for 4 jobs → grant order 0, 1, 0, 1; each ack exactly 1 cycle wide; add overflow A=15, B=1 → 0.
- Reset mid-job: assert `rst_n`=0 during EXEC → immediately state=0, all `dp_*`=0, no ack. Release reset with `req0` held → job re-runs and acks correctly.
- Operand change after grant: change `a0` in LOAD1 → result uses the latched A; `req0` dropped after grant → `ack0` still pulses.
